// File: rtl/addsub_pkg.sv
// Shared types for the 8-bit add/sub unit and its issue controller.
package addsub_pkg;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       control_in;
   } input_port;

   typedef struct packed {
      logic [7:0] result_out;
      logic       flag_out;
   } output_port;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
   } addsub_req_t;

endpackage

// File: rtl/addsub_fifo.sv
// DEPTH-entry request FIFO with a combinational head that reads as zero when empty.
module addsub_fifo
   import addsub_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        push,
   input  addsub_req_t wr_data,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output addsub_req_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   addsub_req_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (do_pop && !do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/combo_logic.sv
// Combinational 8-bit add/sub; flag_out is carry for add and not-borrow for sub.
module combo_logic
   import addsub_pkg::*;
(
   input  input_port  p1,
   output output_port p2
);

   logic [7:0] b_opnd;
   logic [8:0] sum;

   // Subtraction as a + ~b + 1 so the carry out directly means "no borrow".
   assign b_opnd        = p1.control_in ? ~p1.b : p1.b;
   assign sum           = {1'b0, p1.a} + {1'b0, b_opnd} + {8'b0, p1.control_in};
   assign p2.result_out = sum[7:0];
   assign p2.flag_out   = sum[8];

endmodule

// File: rtl/addsub_issue_ctrl.sv
// Request FIFO front end and registered response stage for combo_logic.
// Optional issue/carry statistics counters: ADDSUB_ISSUE_CTRL_STATS_EN.
module addsub_issue_ctrl
   import addsub_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_a,
   input  logic [7:0]  req_b,
   input  logic        req_sub,
   output input_port   alu_p1,
   input  output_port  alu_p2,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_result,
   output logic        rsp_carry,
`ifdef ADDSUB_ISSUE_CTRL_STATS_EN
   output logic        rsp_zero,
   output logic [15:0] op_count,
   output logic [15:0] carry_count
`else
   output logic        rsp_zero
`endif
);

   addsub_req_t wr_req;
   addsub_req_t head;
   logic        full, empty;
   logic        push, issue;

   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_result_q, rsp_result_d;
   logic        rsp_carry_q, rsp_carry_d;
   logic        rsp_zero_q, rsp_zero_d;

   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign wr_req    = '{a: req_a, b: req_b, sub: req_sub};
   assign alu_p1    = '{a: head.a, b: head.b, control_in: head.sub};

   // The response slot is free when empty or being consumed on this same edge.
   assign issue = !empty && (!rsp_valid_q || rsp_ready);

   addsub_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (push),
      .wr_data (wr_req),
      .pop     (issue),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      if (flush) begin
         rsp_valid_d = 1'b0;
      end else if (issue) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = alu_p2.result_out;
         rsp_carry_d  = alu_p2.flag_out;
         rsp_zero_d   = (alu_p2.result_out == 8'h00);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 8'h00;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;

`ifdef ADDSUB_ISSUE_CTRL_STATS_EN
   logic [15:0] op_count_q, op_count_d;
   logic [15:0] carry_count_q, carry_count_d;

   always_comb begin
      op_count_d    = op_count_q;
      carry_count_d = carry_count_q;
      if (flush) begin
         op_count_d    = '0;
         carry_count_d = '0;
      end else if (issue) begin
         op_count_d = op_count_q + 1'b1;
         if (alu_p2.flag_out) carry_count_d = carry_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q    <= '0;
         carry_count_q <= '0;
      end else begin
         op_count_q    <= op_count_d;
         carry_count_q <= carry_count_d;
      end
   end

   assign op_count    = op_count_q;
   assign carry_count = carry_count_q;
`endif

endmodule
